bcd_btn_counter: RTL and testbench
==================================

// Module: bcd_btn_counter
// PURPOSE
//  Upstream stage of seg_7_func. Debounces two raw push-buttons (up/down) and
//  keeps a modulo-(MAX_COUNT+1) BCD digit. bcd[3:0] feeds seg_7_func directly:
//  bcd[3]->A, bcd[2]->B, bcd[1]->C, bcd[0]->D.
//  One clean press changes the digit by exactly one. Carry/borrow pulses allow
//  a later multi-digit cascade.
// PARAMETERS
//  DEBOUNCE_CYCLES  120000  stable cycles required to accept a press/release (>=2; 10 ms @ 12 MHz)
//  MAX_COUNT        9       highest digit value before wrap (1..15)
// PORTS
//  clk       in   1  system clock, all flops on rising edge
//  rst       in   1  asynchronous, active-high reset
//  btn_up    in   1  raw, asynchronous, bouncy button; 1 = pressed
//  btn_down  in   1  raw, asynchronous, bouncy button; 1 = pressed
//  bcd       out  4  current digit, 0..MAX_COUNT, registered
//  carry     out  1  1-cycle pulse when up-count wraps MAX_COUNT->0
//  borrow    out  1  1-cycle pulse when down-count wraps 0->MAX_COUNT
// BEHAVIOUR
//  Reset (async assert, sync release): bcd=0, carry=0, borrow=0,
//   synchroniser flops=0, both FSMs IDLE, debounce counters=0.
//  Each button path:
//   - 2-flop synchroniser. btn_sync is the second flop.
//   - Own FSM plus debounce counter, width $clog2(DEBOUNCE_CYCLES).
//   IDLE:         sync=1 -> WAIT_PRESS, cnt=0.
//   WAIT_PRESS:   sync=0 -> IDLE (glitch rejected, no count).
//                 sync=1 & cnt==DEBOUNCE_CYCLES-1 -> PRESSED, raise press event.
//                 else cnt++.
//   PRESSED:      sync=0 -> WAIT_RELEASE, cnt=0. Holding gives no auto-repeat.
//   WAIT_RELEASE: sync=1 -> PRESSED (release bounce, no new event).
//                 sync=0 & cnt==DEBOUNCE_CYCLES-1 -> IDLE. Else cnt++.
//  Press event = the FSM's WAIT_PRESS->PRESSED transition. bcd updates on that
//   same edge.
//  Latency: raw input rises and is held -> bcd changes on rising edge
//   DEBOUNCE_CYCLES+3 after the rise (2 synchroniser edges + IDLE edge +
//   DEBOUNCE_CYCLES count edges).
//  Counting:
//   - up event only: bcd==MAX_COUNT ? 0 (carry=1) : bcd+1.
//   - down event only: bcd==0 ? MAX_COUNT (borrow=1) : bcd-1.
//   - up and down events on the same edge: bcd unchanged, carry=borrow=0.
//   - carry/borrow are registered and high for exactly one cycle, aligned with
//     the new bcd value. Otherwise 0.
//  bcd never leaves 0..MAX_COUNT. Values MAX_COUNT+1..15 are unreachable.
//  Reset mid-debounce or while held: all state cleared at once. A button still
//   held after rst deasserts is debounced from IDLE and counts once.
//  Up and down paths are independent. Holding one button does not block the
//   other.
// TESTING (bench overrides DEBOUNCE_CYCLES=4, MAX_COUNT=9)
//  1 Reset: rst=1 with random buttons -> bcd=0, carry=0, borrow=0 immediately,
//    before any clk edge.
//  2 Clean up press held 20 cycles -> bcd 0->1 exactly on edge 7 after the rise.
//    Held 20 more cycles -> stays 1.
//  3 Bounce: btn_up toggles 1,0,1,0 each cycle, then held high -> exactly one
//    increment. A 3-cycle glitch alone -> no change.
//  4 Wrap: 10 up presses from 0 -> 1..9, then 0 with carry=1 for one cycle.
//    One down press from 0 -> 9 with borrow=1 for one cycle.
//  5 Simultaneous: up and down rise on the same cycle from bcd=5 -> bcd stays 5,
//    no carry/borrow. Up then down offset by 10 cycles -> 6 then 5.
//  6 rst pulse during WAIT_PRESS, button still held -> bcd=0. One increment
//    occurs 7 edges after rst release.

Source files
------------

// File: rtl/bcd_btn_counter.sv
// Two-button BCD digit counter.
// Each raw button runs through a 2-flop synchroniser and a debounce FSM.
// A debounced press steps the digit up or down, modulo MAX_COUNT+1.
// carry and borrow are one-cycle pulses that a later digit stage can chain on.

// Single button path: synchroniser, debounce FSM and press strobe.
module bcd_btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 120000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_i,
  output logic press_o
);

  // The counter only has to reach DEBOUNCE_CYCLES-1, so $clog2 bits are enough.
  localparam int unsigned    CW       = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    WAIT_PRESS   = 2'd1,
    PRESSED      = 2'd2,
    WAIT_RELEASE = 2'd3
  } state_e;

  logic [1:0]    sync_q;
  logic          btn_sync;
  state_e        state_q;
  logic [CW-1:0] cnt_q;

  assign btn_sync = sync_q[1];

  // Two-flop synchroniser for the asynchronous, bouncy raw input.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[0], btn_i};
  end

  // Debounce FSM: a level must hold for DEBOUNCE_CYCLES+1 sampled cycles before
  // the FSM accepts it. A release bounce returns to PRESSED, so holding the
  // button never produces a second press.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (btn_sync) begin
            state_q <= WAIT_PRESS;
            cnt_q   <= '0;
          end
        end
        WAIT_PRESS: begin
          if (!btn_sync)               state_q <= IDLE;
          else if (cnt_q == CNT_LAST)  state_q <= PRESSED;
          else                         cnt_q   <= cnt_q + 1'b1;
        end
        PRESSED: begin
          if (!btn_sync) begin
            state_q <= WAIT_RELEASE;
            cnt_q   <= '0;
          end
        end
        WAIT_RELEASE: begin
          if (btn_sync)                state_q <= PRESSED;
          else if (cnt_q == CNT_LAST)  state_q <= IDLE;
          else                         cnt_q   <= cnt_q + 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Press strobe is the WAIT_PRESS->PRESSED transition itself. It is decoded
  // from current state so the digit register updates on that same edge.
  assign press_o = (state_q == WAIT_PRESS) && btn_sync && (cnt_q == CNT_LAST);

endmodule

// Top: two debounced button paths driving a modulo-(MAX_COUNT+1) BCD digit.
module bcd_btn_counter #(
  parameter int unsigned DEBOUNCE_CYCLES = 120000,
  parameter int unsigned MAX_COUNT       = 9
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_up,
  input  logic       btn_down,
  output logic [3:0] bcd,
  output logic       carry,
  output logic       borrow
);

  localparam int unsigned NUM_BTN = 2;
  localparam int unsigned BTN_UP  = 0;
  localparam int unsigned BTN_DN  = 1;
  localparam logic [3:0]  MAX_BCD = 4'(MAX_COUNT);

  logic [NUM_BTN-1:0] btn_raw;
  logic [NUM_BTN-1:0] press;

  logic [3:0] bcd_q, bcd_d;
  logic       carry_q, carry_d;
  logic       borrow_q, borrow_d;

  assign btn_raw[BTN_UP] = btn_up;
  assign btn_raw[BTN_DN] = btn_down;

  // One independent debounce path per button.
  for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
    bcd_btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .clk     (clk),
      .rst     (rst),
      .btn_i   (btn_raw[g]),
      .press_o (press[g])
    );
  end

  // Next digit: step up or down with wrap. Coincident presses cancel out.
  always_comb begin
    bcd_d    = bcd_q;
    carry_d  = 1'b0;
    borrow_d = 1'b0;
    if (press[BTN_UP] && !press[BTN_DN]) begin
      if (bcd_q == MAX_BCD) begin
        bcd_d   = 4'd0;
        carry_d = 1'b1;
      end else begin
        bcd_d   = bcd_q + 4'd1;
      end
    end else if (press[BTN_DN] && !press[BTN_UP]) begin
      if (bcd_q == 4'd0) begin
        bcd_d    = MAX_BCD;
        borrow_d = 1'b1;
      end else begin
        bcd_d    = bcd_q - 4'd1;
      end
    end
  end

  // Digit and wrap pulses are registered together so they stay aligned.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bcd_q    <= 4'd0;
      carry_q  <= 1'b0;
      borrow_q <= 1'b0;
    end else begin
      bcd_q    <= bcd_d;
      carry_q  <= carry_d;
      borrow_q <= borrow_d;
    end
  end

  assign bcd    = bcd_q;
  assign carry  = carry_q;
  assign borrow = borrow_q;

endmodule

// File: tb/tb_bcd_btn_counter.sv
// Bench for bcd_btn_counter: run-length debounce model plus directed and random stimulus.
module tb_bcd_btn_counter;

  localparam int DB = 4;
  localparam int MC = 9;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       btn_up = 1'b0;
  logic       btn_down = 1'b0;
  logic [3:0] bcd;
  logic       carry;
  logic       borrow;

  int n_vec = 0;
  int n_err = 0;
  bit started = 1'b0;

  always #5 clk = ~clk;

  bcd_btn_counter #(
    .DEBOUNCE_CYCLES(DB),
    .MAX_COUNT(MC)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .btn_up   (btn_up),
    .btn_down (btn_down),
    .bcd      (bcd),
    .carry    (carry),
    .borrow   (borrow)
  );

  // Model: a press/release is accepted when the synchronised level differs from
  // the debounced level for DB+1 consecutive samples.
  typedef struct packed {
    logic [1:0]  dl;
    logic [31:0] run;
    logic        last;
    logic        deb;
    logic        ev;
  } path_t;

  path_t mu, md;
  int    m_bcd;
  logic  m_carry, m_borrow;

  function automatic path_t path_step(input path_t p, input logic raw);
    path_t n;
    logic  s;
    n    = p;
    s    = p.dl[1];
    n.dl = {p.dl[0], raw};
    n.ev = 1'b0;
    n.run  = (s == p.last) ? p.run + 1 : 32'd1;
    n.last = s;
    if (s != p.deb && n.run == DB + 1) begin
      n.deb = s;
      n.ev  = s;
    end
    return n;
  endfunction

  function automatic logic path_ev(input path_t p, input logic raw);
    path_t n;
    n = path_step(p, raw);
    return n.ev;
  endfunction

  function automatic int next_bcd(input int b, input logic up, input logic dn);
    if (up && !dn) return (b + 1) % (MC + 1);
    if (dn && !up) return (b + MC) % (MC + 1);
    return b;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mu       <= '0;
      md       <= '0;
      m_bcd    <= 0;
      m_carry  <= 1'b0;
      m_borrow <= 1'b0;
    end else begin
      mu       <= path_step(mu, btn_up);
      md       <= path_step(md, btn_down);
      m_bcd    <= next_bcd(m_bcd, path_ev(mu, btn_up), path_ev(md, btn_down));
      m_carry  <= path_ev(mu, btn_up) && !path_ev(md, btn_down) && (m_bcd == MC);
      m_borrow <= path_ev(md, btn_down) && !path_ev(mu, btn_up) && (m_bcd == 0);
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Pin both DUT and model to a hand-computed digit.
  task automatic pin(input string nm, input int exp);
    check({nm, "_dut"}, bcd, exp);
    check({nm, "_model"}, m_bcd, exp);
  endtask

  // Cycle-by-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (started) begin
      check("cyc_bcd", bcd, m_bcd);
      check("cyc_carry", carry, m_carry);
      check("cyc_borrow", borrow, m_borrow);
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Clean press: capture outputs on the event edge (7) and the one after.
  task automatic press(input bit up, output logic [3:0] b7, output logic c7,
                       output logic w7, output logic c8, output logic w8);
    if (up) btn_up = 1'b1; else btn_down = 1'b1;
    tick(7);
    b7 = bcd; c7 = carry; w7 = borrow;
    tick(1);
    c8 = carry; w8 = borrow;
    tick(12);
    btn_up = 1'b0;
    btn_down = 1'b0;
    tick(10);
  endtask

  logic [3:0] b7;
  logic       c7, w7, c8, w8;

  initial begin
    // Reset with random buttons: outputs clear before any clock edge.
    #1;
    rst = 1'b1;
    btn_up = 1'($urandom_range(0, 1));
    btn_down = 1'($urandom_range(0, 1));
    #1;
    check("rst_bcd", bcd, 0);
    check("rst_carry", carry, 0);
    check("rst_borrow", borrow, 0);
    started = 1'b1;
    tick(3);
    btn_up = 1'b0;
    btn_down = 1'b0;
    tick(1);
    rst = 1'b0;
    tick(2);

    // Clean up press: increments on edge 7, no auto-repeat.
    btn_up = 1'b1;
    tick(6);
    pin("press_e6", 0);
    tick(1);
    pin("press_e7", 1);
    tick(13);
    pin("press_held20", 1);
    tick(20);
    pin("press_held40", 1);
    btn_up = 1'b0;
    tick(10);

    // Bounce then hold: one increment. Short glitch: none.
    for (int i = 0; i < 4; i++) begin
      btn_up = (i % 2 == 0);
      tick(1);
    end
    btn_up = 1'b1;
    tick(20);
    pin("bounce", 2);
    btn_up = 1'b0;
    tick(10);
    btn_up = 1'b1;
    tick(3);
    btn_up = 1'b0;
    tick(15);
    pin("glitch", 2);

    // Wrap up from 0 with carry, then down from 0 with borrow.
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    tick(2);
    pin("rst_again", 0);
    for (int i = 1; i <= 10; i++) begin
      press(1'b1, b7, c7, w7, c8, w8);
      check("wrap_up_bcd", b7, i % 10);
      check("wrap_up_carry", c7, (i == 10) ? 1 : 0);
      check("wrap_up_carry_next", c8, 0);
    end
    press(1'b0, b7, c7, w7, c8, w8);
    check("wrap_dn_bcd", b7, 9);
    check("wrap_dn_borrow", w7, 1);
    check("wrap_dn_borrow_next", w8, 0);
    for (int i = 8; i >= 5; i--) begin
      press(1'b0, b7, c7, w7, c8, w8);
      check("down_bcd", b7, i);
      check("down_borrow", w7, 0);
    end

    // Simultaneous presses cancel; offset presses both count.
    btn_up = 1'b1;
    btn_down = 1'b1;
    tick(7);
    pin("simul_e7", 5);
    check("simul_carry", carry, 0);
    check("simul_borrow", borrow, 0);
    tick(13);
    btn_up = 1'b0;
    btn_down = 1'b0;
    tick(10);
    pin("simul_after", 5);
    btn_up = 1'b1;
    tick(7);
    pin("offset_up", 6);
    tick(3);
    btn_down = 1'b1;
    tick(6);
    pin("offset_dn_e6", 6);
    tick(1);
    pin("offset_dn_e7", 5);
    tick(5);
    btn_up = 1'b0;
    btn_down = 1'b0;
    tick(10);

    // Reset during WAIT_PRESS with button held: counts once after release.
    btn_up = 1'b1;
    tick(4);
    rst = 1'b1;
    #1;
    check("midrst_bcd", bcd, 0);
    tick(1);
    rst = 1'b0;
    tick(6);
    pin("midrst_e6", 0);
    tick(1);
    pin("midrst_e7", 1);
    tick(10);
    btn_up = 1'b0;
    tick(10);

    // Random segments of button levels, with occasional reset pulses.
    for (int s = 0; s < 300; s++) begin
      btn_up = 1'($urandom_range(0, 1));
      btn_down = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 39) == 0) begin
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
      end
      tick($urandom_range(1, 14));
    end
    btn_up = 1'b0;
    btn_down = 1'b0;
    tick(12);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
